// File: rtl/button_event_arbiter.sv
// Turns debounced button levels into discrete move events: edge detect, per-button pending
// latch, round-robin arbitration, small event FIFO and optional auto-repeat of a lone held button.
module button_event_arbiter #(
  parameter int FIFO_DEPTH  = 4,
  parameter int HOLD_CYCLES = 25000000,
  parameter int REPEAT_EN   = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] btn_level,
  input  logic       evt_ready,
  output logic       evt_valid,
  output logic [1:0] evt_code,
  output logic [7:0] drop_cnt,
  output logic       busy
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [3:0]    r_prev_lvl;
  logic [3:0]    r_pending;
  logic [1:0]    r_rr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [AW:0]   r_count;
  logic [31:0]   r_rpt_cnt;
  logic [7:0]    r_drop_cnt;
  logic [1:0]    r_evt_code;
  logic [1:0]    r_mem [FIFO_DEPTH];

  logic [3:0]    w_rise;
  logic          w_onehot;
  logic          w_hold;
  logic          w_rpt_tick;
  logic [3:0]    w_set;
  logic [3:0]    w_grant_vec;
  logic [3:0]    w_drop_vec;
  logic [3:0]    w_pending_next;
  logic          w_grant_vld;
  logic [1:0]    w_grant_idx;
  logic          w_pop;
  logic          w_push_ok;
  logic          w_push;
  logic [AW-1:0] w_rd_next;
  logic [AW:0]   w_count_next;
  logic [8:0]    w_drop_sum;

  assign w_rise   = btn_level & ~r_prev_lvl;
  assign w_onehot = (btn_level != 4'd0) && ((btn_level & (btn_level - 4'd1)) == 4'd0);
  assign w_hold   = (REPEAT_EN != 0) && w_onehot && (btn_level == r_prev_lvl);
  assign w_rpt_tick = w_hold && (r_rpt_cnt == 32'(HOLD_CYCLES - 1));
  assign w_set    = w_rise | (w_rpt_tick ? btn_level : 4'd0);

  // First pending bit at or after rr_ptr, scanning downward so the smallest offset wins.
  always_comb begin
    logic [1:0] w_idx;
    w_grant_vld = 1'b0;
    w_grant_idx = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      w_idx = r_rr_ptr + 2'(k);
      if (r_pending[w_idx]) begin
        w_grant_vld = 1'b1;
        w_grant_idx = w_idx;
      end
    end
  end

  assign evt_valid = (r_count != '0);
  assign w_pop     = evt_valid && evt_ready;
  assign w_push_ok = (r_count < (AW+1)'(FIFO_DEPTH)) || w_pop;
  assign w_push    = w_grant_vld && w_push_ok;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_bit
      assign w_grant_vec[gi]    = w_push && (w_grant_idx == 2'(gi));
      assign w_drop_vec[gi]     = w_set[gi] && r_pending[gi] && !w_grant_vec[gi];
      assign w_pending_next[gi] = (r_pending[gi] && !w_grant_vec[gi]) || w_set[gi];
    end
  endgenerate

  assign w_drop_sum = 9'(r_drop_cnt) + 9'(w_drop_vec[0]) + 9'(w_drop_vec[1])
                    + 9'(w_drop_vec[2]) + 9'(w_drop_vec[3]);

  assign w_rd_next    = w_pop ? r_rd_ptr + AW'(1) : r_rd_ptr;
  assign w_count_next = r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_prev_lvl <= 4'd0;
      r_pending  <= 4'd0;
      r_rr_ptr   <= 2'd0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_rpt_cnt  <= 32'd0;
      r_drop_cnt <= 8'd0;
      r_evt_code <= 2'd0;
    end else begin
      r_prev_lvl <= btn_level;
      r_pending  <= w_pending_next;
      r_drop_cnt <= (w_drop_sum > 9'd255) ? 8'd255 : w_drop_sum[7:0];
      if (w_hold && !w_rpt_tick) begin
        r_rpt_cnt <= r_rpt_cnt + 32'd1;
      end else begin
        r_rpt_cnt <= 32'd0;
      end
      if (w_push) begin
        r_rr_ptr <= w_grant_idx + 2'd1;
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      r_rd_ptr <= w_rd_next;
      r_count  <= w_count_next;
      // Head register: a slot being written this cycle is not yet in the array.
      if (w_count_next != '0) begin
        if (w_push && (w_rd_next == r_wr_ptr)) begin
          r_evt_code <= w_grant_idx;
        end else begin
          r_evt_code <= r_mem[w_rd_next];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_grant_idx;
    end
  end

  assign evt_code = r_evt_code;
  assign drop_cnt = r_drop_cnt;
  assign busy     = (r_pending != 4'd0) || (r_count != '0);

endmodule

// File: tb/tb_button_event_arbiter.sv
// Directed stimulus for button_event_arbiter; expected event codes go into a queue that
// a negedge monitor consumes on every accepted handshake.
module tb_button_event_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] btn_level;
  logic       evt_ready;
  logic       evt_valid;
  logic [1:0] evt_code;
  logic [7:0] drop_cnt;
  logic       busy;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_q[$];

  button_event_arbiter #(.FIFO_DEPTH(4), .HOLD_CYCLES(8), .REPEAT_EN(1)) dut (
    .clk(clk), .reset(reset), .btn_level(btn_level), .evt_ready(evt_ready),
    .evt_valid(evt_valid), .evt_code(evt_code), .drop_cnt(drop_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) begin
      n_pass++;
      $display("check %-16s got %0d expected %0d ok", name, act, exp);
    end else begin
      $display("FAIL %-16s got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    exp_q.delete();
    tick(2);
    reset = 1'b0;
  endtask

  task automatic press(input logic [3:0] b, input int hold);
    btn_level = b;
    tick(hold);
    btn_level = 4'd0;
    tick(1);
  endtask

  task automatic drain();
    evt_ready = 1'b1;
    for (int c = 0; c < 200 && (exp_q.size() != 0 || evt_valid); c++) tick(1);
    chk("drain_q_left", exp_q.size(), 0);
    chk("drain_valid", int'(evt_valid), 0);
  endtask

  always @(negedge clk) begin
    if (!reset && evt_valid && evt_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL evt_unexpected   got code %0d expected no event", evt_code);
      end else begin
        chk("evt_code", int'(evt_code), exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog          got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; btn_level = 4'd0; evt_ready = 1'b0;
    tick(3);
    chk("rst_valid", int'(evt_valid), 0);
    chk("rst_code", int'(evt_code), 0);
    chk("rst_drop", int'(drop_cnt), 0);
    chk("rst_busy", int'(busy), 0);
    reset = 1'b0;
    evt_ready = 1'b1;
    tick(2);

    // single press: pending after first edge, valid after second, gone after third
    btn_level = 4'b0010;
    exp_q.push_back(1);
    tick(1);
    chk("t1_valid_k", int'(evt_valid), 0);
    chk("t1_busy_k", int'(busy), 1);
    tick(1);
    chk("t1_valid_k1", int'(evt_valid), 1);
    chk("t1_code_k1", int'(evt_code), 1);
    btn_level = 4'd0;
    tick(1);
    chk("t1_valid_k2", int'(evt_valid), 0);
    drain();

    // simultaneous press from rr_ptr=0, then 1010 confirms rr_ptr wrapped to 0
    do_reset();
    evt_ready = 1'b1;
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(3);
    press(4'b1011, 2);
    drain();
    exp_q.push_back(1); exp_q.push_back(3);
    press(4'b1010, 2);
    drain();

    // backpressure: four entries fill the FIFO, fifth press waits in pending
    evt_ready = 1'b0;
    for (int b = 0; b < 4; b++) begin
      exp_q.push_back(b);
      press(4'(1 << b), 1);
    end
    exp_q.push_back(0);
    press(4'b0001, 1);
    tick(2);
    chk("t3_valid", int'(evt_valid), 1);
    chk("t3_busy", int'(busy), 1);
    chk("t3_head", int'(evt_code), 0);
    drain();
    chk("t3_drop", int'(drop_cnt), 0);
    chk("t3_busy_end", int'(busy), 0);

    // merge: button 2 pressed twice while FIFO full
    evt_ready = 1'b0;
    exp_q.push_back(0); press(4'b0001, 1);
    exp_q.push_back(1); press(4'b0010, 1);
    exp_q.push_back(3); press(4'b1000, 1);
    exp_q.push_back(1); press(4'b0010, 1);
    exp_q.push_back(2);
    press(4'b0100, 1);
    press(4'b0100, 1);
    chk("t4_drop", int'(drop_cnt), 1);
    drain();
    chk("t4_drop_end", int'(drop_cnt), 1);

    // auto-repeat: lone hold gives press + repeats at 8, 16, 24 cycles
    evt_ready = 1'b1;
    repeat (4) exp_q.push_back(2);
    press(4'b0100, 30);
    drain();
    // two buttons held: rr_ptr=3 after last grant of 2, so 0 then 2, no repeats
    exp_q.push_back(0); exp_q.push_back(2);
    press(4'b0101, 30);
    drain();

    // reset mid-operation with a button held through it
    evt_ready = 1'b0;
    exp_q.push_back(0); press(4'b0001, 1);
    exp_q.push_back(1); press(4'b0010, 1);
    exp_q.push_back(2);
    btn_level = 4'b0100;
    tick(2);
    chk("t6_busy_pre", int'(busy), 1);
    reset = 1'b1;
    exp_q.delete();
    tick(1);
    reset = 1'b0;
    chk("t6_valid", int'(evt_valid), 0);
    chk("t6_drop", int'(drop_cnt), 0);
    chk("t6_busy", int'(busy), 0);
    exp_q.push_back(2);
    evt_ready = 1'b1;
    tick(2);
    chk("t6_held_valid", int'(evt_valid), 1);
    btn_level = 4'd0;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
